// File: rtl/victim_buffer_ctrl.sv
// Victim buffer control/metadata: 8 slots, swap-back on hit, dirty writeback to pmem.
// Optional VICTIM_BG_DRAIN_EN: idle FSM also writes back the lowest dirty slot in the background.
module victim_buffer_ctrl #(
  parameter int width       = 256,
  parameter int OFFSET_BITS = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             evict_valid,
  input  logic [15:0]      evict_addr,
  input  logic             evict_dirty,
  input  logic [width-1:0] evict_data,
  output logic             evict_ready,
  input  logic             lookup_valid,
  input  logic [15:0]      lookup_addr,
  input  logic             lookup_take,
  output logic             lookup_hit,
  output logic             lookup_dirty,
  output logic [width-1:0] lookup_data,
  output logic [2:0]       arr_index,
  output logic             arr_load,
  output logic [width-1:0] arr_in,
  input  logic [width-1:0] arr_out,
  output logic [15:0]      pmem_address,
  output logic [width-1:0] pmem_wdata,
  output logic             pmem_write,
  input  logic             pmem_resp
);
  localparam int TAG_W = 16 - OFFSET_BITS;

  typedef enum logic {IDLE, DRAIN} state_e;

  state_e           state_q;
  logic [7:0]       valid_q, dirty_q;
  logic [TAG_W-1:0] tag_q [8];
  logic [2:0]       wr_ptr_q, wr_ptr_d, d_idx_q;
  logic             pmem_write_q;
  logic [15:0]      pmem_address_q;

  logic [TAG_W-1:0] ltag, etag;
  logic             hit_any, dup_any, dirty_any;
  logic [2:0]       hit_idx, dup_idx, dirty_idx, target, drain_idx;
  logic             idle, swap, wr_blocked, accept, new_dirty, drain_go;

  assign ltag = lookup_addr[15:OFFSET_BITS];
  assign etag = evict_addr[15:OFFSET_BITS];
  assign idle = (state_q == IDLE);

  // Descending scan leaves the lowest matching index in each encoder.
  always_comb begin
    hit_any   = 1'b0;
    hit_idx   = 3'd0;
    dup_any   = 1'b0;
    dup_idx   = 3'd0;
    dirty_any = 1'b0;
    dirty_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (valid_q[i] && tag_q[i] == ltag) begin
        hit_any = 1'b1;
        hit_idx = 3'(i);
      end
      if (valid_q[i] && tag_q[i] == etag) begin
        dup_any = 1'b1;
        dup_idx = 3'(i);
      end
      if (valid_q[i] && dirty_q[i]) begin
        dirty_any = 1'b1;
        dirty_idx = 3'(i);
      end
    end
  end

  assign lookup_hit = lookup_valid & idle & hit_any;
  assign swap       = lookup_hit & lookup_take & evict_valid;
  assign target     = swap ? hit_idx : (dup_any ? dup_idx : wr_ptr_q);
  assign wr_blocked = valid_q[wr_ptr_q] & dirty_q[wr_ptr_q];
  assign accept     = idle & evict_valid & ~rst
                    & ~(lookup_valid & ~(lookup_hit & lookup_take))
                    & ~((target == wr_ptr_q) & wr_blocked);
  assign new_dirty  = (!swap && dup_any) ? (dirty_q[target] | evict_dirty) : evict_dirty;
  assign wr_ptr_d   = (accept && target == wr_ptr_q) ? wr_ptr_q + 3'd1 : wr_ptr_q;

`ifdef VICTIM_BG_DRAIN_EN
  assign drain_go  = (evict_valid & wr_blocked) | dirty_any;
`else
  assign drain_go  = evict_valid & wr_blocked;
`endif
  assign drain_idx = (evict_valid & wr_blocked) ? wr_ptr_q : dirty_idx;

  assign evict_ready  = accept;
  assign arr_load     = accept;
  assign arr_in       = evict_data;
  assign arr_index    = !idle ? d_idx_q : (accept ? target : (lookup_hit ? hit_idx : 3'd0));
  assign lookup_dirty = lookup_hit & dirty_q[hit_idx];
  assign lookup_data  = lookup_hit ? arr_out : '0;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_write_q ? arr_out : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      valid_q        <= '0;
      dirty_q        <= '0;
      wr_ptr_q       <= '0;
      d_idx_q        <= '0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          wr_ptr_q <= wr_ptr_d;
          if (accept) begin
            valid_q[target] <= 1'b1;
            dirty_q[target] <= new_dirty;
            tag_q[target]   <= etag;
          end else begin
            if (lookup_hit && lookup_take) begin
              valid_q[hit_idx] <= 1'b0;
              dirty_q[hit_idx] <= 1'b0;
            end
            if (!lookup_valid && drain_go) begin
              state_q        <= DRAIN;
              d_idx_q        <= drain_idx;
              pmem_write_q   <= 1'b1;
              pmem_address_q <= {tag_q[drain_idx], {OFFSET_BITS{1'b0}}};
            end
          end
        end
        DRAIN: begin
          // Line stays resident and clean once memory has it.
          if (pmem_resp) begin
            dirty_q[d_idx_q] <= 1'b0;
            state_q          <= IDLE;
            pmem_write_q     <= 1'b0;
            pmem_address_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/victim_buffer_ctrl.md
Name: victim_buffer_ctrl

Overview:
- Control and metadata side of the 8-entry victim buffer; drives the external line-data array (3-bit index, load, write data; combinational read data).
- Accepts lines evicted from L2, answers L2 miss lookups and supports swap-back on a hit.
- Writes dirty victims back to physical memory over the pmem write handshake.
- Sits between the L2 controller and physical memory.

Parameters:
- width, 256, line width in bits; must match the data array.
- OFFSET_BITS, 5, line byte-offset bits; tag = addr[15:OFFSET_BITS] (11 bits at default).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- evict_valid  in  1  L2 offers an evicted line.
- evict_addr  in  16  line address of the evicted line.
- evict_dirty  in  1  evicted line is dirty.
- evict_data  in  width  evicted line data.
- evict_ready  out  1  insertion accepted at this clock edge.
- lookup_valid  in  1  L2 miss lookup is active.
- lookup_addr  in  16  lookup address.
- lookup_take  in  1  remove the hit line (swap back into L2).
- lookup_hit  out  1  tag match on a valid entry.
- lookup_dirty  out  1  dirty bit of the hit entry.
- lookup_data  out  width  line data of the hit entry.
- arr_index  out  3  data array index.
- arr_load  out  1  data array write enable.
- arr_in  out  width  data array write data.
- arr_out  in  width  data array read data (combinational).
- pmem_address  out  16  writeback address, {tag, OFFSET_BITS'b0}.
- pmem_wdata  out  width  writeback data.
- pmem_write  out  1  writeback request.
- pmem_resp  in  1  writeback done.

Behaviour:
- State per slot: valid[8], dirty[8], tag[8]. Also a 3-bit round-robin wr_ptr and FSM {IDLE, DRAIN} with latched 3-bit d_idx.
- Reset: valid=0, dirty=0, wr_ptr=0, state=IDLE. Every output is 0 except arr_in, which follows evict_data. Array contents are not cleared.
- Reset during DRAIN: pmem_write deasserts the next cycle and that dirty line is discarded. This is intended behaviour.
- Lookup (combinational):
  - lookup_hit = lookup_valid & (state==IDLE) & any slot with valid & tag==lookup tag.
  - When hit: arr_index = hit slot, lookup_data = arr_out.
  - At most one match is guaranteed by the insertion rules.
- Insertion target, in priority order:
  - Swap: lookup_hit & lookup_take & evict_valid → the hit slot.
  - Duplicate: a valid slot whose tag equals the evict tag → that slot. New dirty = old dirty | evict_dirty.
  - Otherwise → wr_ptr.
- evict_ready = (state==IDLE) & evict_valid & !(lookup_valid & !(lookup_hit & lookup_take)) & !(target==wr_ptr & valid[wr_ptr] & dirty[wr_ptr]).
- On an accepted insertion:
  - arr_index = target, arr_load = 1, arr_in = evict_data.
  - At the edge: valid=1, tag and dirty written.
  - wr_ptr increments (wraps 7→0) only when target==wr_ptr.
- Swap: arr_out is sampled before the edge, so lookup_data is the old line and the new line is written in the same cycle. Zero-cycle swap.
- lookup_take with no insertion: at the edge, valid and dirty of the hit slot are cleared and wr_ptr is unchanged.
- IDLE→DRAIN, only when no lookup_valid and no accepted insertion this cycle:
  - Pending evict_valid with valid & dirty at wr_ptr → d_idx = wr_ptr.
  - Otherwise, background drain candidates (see feature) → d_idx = lowest dirty index.
- DRAIN:
  - arr_index = d_idx, arr_load = 0, pmem_write = 1.
  - pmem_wdata = arr_out, pmem_address = {tag[d_idx], OFFSET_BITS'b0}.
  - Outputs are held stable until pmem_resp.
  - On pmem_resp: dirty[d_idx] = 0 (the entry stays valid and clean), return to IDLE, pmem_write = 0 the next cycle.
- In DRAIN: evict_ready = 0, lookup_hit = 0.

Optional Feature:
- Macro: VICTIM_BG_DRAIN_EN.
- Defined: IDLE also enters DRAIN for the lowest-index dirty slot whenever the FSM is idle, with no pending lookup or insert.
- Undefined: lazy writeback. DRAIN is entered only for a dirty wr_ptr slot blocking a pending evict_valid.

Test Plan:
- Reset, then insert clean lines at addr 0x0020, 0x0040, 0x0060 → arr_load pulses at indices 0,1,2, wr_ptr=3, pmem_write never asserted.
- Lookup 0x0040 with no take → lookup_hit=1, arr_index=1, lookup_data equals inserted data, no metadata change.
- Lookup 0x0040 with take, plus simultaneous evict 0x1000 dirty data 0xAB.. → same cycle: lookup_data is old line, arr_load=1 at index 1. Next cycle: lookup 0x1000 hits with dirty=1.
- Lazy mode (macro undefined): fill 8 dirty lines, then evict a 9th → evict_ready=0, DRAIN on slot 0 with pmem_address=tag0<<5; pmem_resp after 3 cycles → next cycle IDLE, the insert is then accepted into slot 0, wr_ptr=1.
- VICTIM_BG_DRAIN_EN defined: insert dirty lines at slots 2 and 5, then hold inputs idle → writebacks for slot 2 then slot 5, each pmem_write held until pmem_resp; both slots stay valid and clean.
- Assert rst mid-DRAIN → pmem_write=0 the next cycle, all lookups miss, wr_ptr=0.
